// File: rtl/mem_burst_reader.sv
//==============================================================================
// Module      : mem_burst_reader
// Description : DEPTH-word register storage with a write port and a burst
//               engine that streams a contiguous, wrapping address range out
//               over a valid/ready port. Optional macro MEM_RD_BYPASS_EN
//               selects write-first data on a same-cycle load/write collision.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_burst_reader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    input  logic              start_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   len_i,
    output logic              busy_o,
    output logic              rd_valid_o,
    input  logic              rd_ready_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_last_o,
    output logic              done_o
);

    localparam int DEPTH = 2**ADDR_W;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD   = 2'd1;
    localparam logic [1:0] S_STREAM = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   rem_q, rem_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              done_q, done_d;

    logic              w_start_ok;
    logic              w_handshake;
    logic [DATA_W-1:0] w_rd_word;

    assign w_start_ok  = start_i && (len_i != '0);
    assign w_handshake = rd_valid_q && rd_ready_i;

`ifdef MEM_RD_BYPASS_EN
    assign w_rd_word = (wr_en_i && (wr_addr_i == addr_q)) ? wr_data_i : mem_q[addr_q];
`else
    assign w_rd_word = mem_q[addr_q];
`endif

    // Storage is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            addr_q     <= '0;
            rem_q      <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            rem_q      <= rem_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
            done_q     <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (w_start_ok) state_d = S_LOAD;
            S_LOAD:   state_d = S_STREAM;
            S_STREAM: if (w_handshake && rd_last_q) state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    // rem_q counts words not yet handed to the consumer, including the one on the port.
    always_comb begin
        addr_d     = addr_q;
        rem_d      = rem_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;
        rd_last_d  = rd_last_q;
        done_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_start_ok) begin
                    addr_d = base_addr_i;
                    rem_d  = len_i;
                end
            end
            S_LOAD: begin
                rd_data_d  = w_rd_word;
                rd_valid_d = 1'b1;
                rd_last_d  = (rem_q == (ADDR_W+1)'(1));
                addr_d     = addr_q + ADDR_W'(1);
            end
            S_STREAM: begin
                if (w_handshake) begin
                    rem_d = rem_q - (ADDR_W+1)'(1);
                    if (rd_last_q) begin
                        rd_valid_d = 1'b0;
                        rd_last_d  = 1'b0;
                        done_d     = 1'b1;
                    end else begin
                        rd_data_d = w_rd_word;
                        rd_last_d = (rem_q == (ADDR_W+1)'(2));
                        addr_d    = addr_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                rd_valid_d = 1'b0;
                rd_last_d  = 1'b0;
            end
        endcase
    end

    assign busy_o     = (state_q != S_IDLE);
    assign rd_valid_o = rd_valid_q;
    assign rd_data_o  = rd_data_q;
    assign rd_last_o  = rd_last_q;
    assign done_o     = done_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
//==============================================================================
// Module      : tb_mem_burst_reader
// Description : Directed and randomized bursts checked against an array model
//               of the memory (expected word i = mem[(base+i) mod 16]).
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_burst_reader;

    logic       clk = 1'b0;
    logic       rst, wr_en, start, rd_ready;
    logic [3:0] wr_addr, base_addr;
    logic [7:0] wr_data;
    logic [4:0] len;
    logic       busy, rd_valid, rd_last, done;
    logic [7:0] rd_data;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] ref_mem [16];

    always #5 clk = ~clk;

    mem_burst_reader #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .start_i    (start),
        .base_addr_i(base_addr),
        .len_i      (len),
        .busy_o     (busy),
        .rd_valid_o (rd_valid),
        .rd_ready_i (rd_ready),
        .rd_data_o  (rd_data),
        .rd_last_o  (rd_last),
        .done_o     (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input logic [7:0] d);
        wr_en = 1'b1; wr_addr = 4'(a); wr_data = d;
        step();
        wr_en = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic idle_chk(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_valid"}, rd_valid, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    // mode: 0 always ready, 1 stall 2 cycles on word 1, 2 random ready
    task automatic run_burst(input int base, input int ln, input int mode,
                             input bit spam, input bit col);
        logic [7:0] exp_q[$];
        int idx, stall, cyc;
        start = 1'b1; base_addr = 4'(base); len = 5'(ln);
        step();
        chk("load_busy", busy, 1);
        chk("load_valid", rd_valid, 0);
        chk("load_done", done, 0);
        start = spam;
        if (spam) begin
            base_addr = 4'($urandom);
            len = 5'($urandom_range(1, 16));
        end
        for (int i = 0; i < ln; i++) exp_q.push_back(ref_mem[(base + i) % 16]);
        if (col) begin
            wr_en = 1'b1; wr_addr = 4'(base); wr_data = 8'h55;
`ifdef MEM_RD_BYPASS_EN
            exp_q[0] = 8'h55;
`endif
            ref_mem[base] = 8'h55;
        end
        step();
        wr_en = 1'b0;
        chk("latency_valid", rd_valid, 1);
        idx = 0; stall = 0; cyc = 0;
        while (idx < ln && cyc < 200) begin
            chk("strm_busy", busy, 1);
            chk("strm_valid", rd_valid, 1);
            chk("strm_done", done, 0);
            chk($sformatf("data_b%0d_w%0d", base, idx), rd_data, exp_q[idx]);
            chk($sformatf("last_b%0d_w%0d", base, idx), rd_last, 32'(idx == ln - 1));
            case (mode)
                0: rd_ready = 1'b1;
                1: begin
                    rd_ready = !(idx == 1 && stall < 2);
                    if (!rd_ready) stall++;
                end
                default: rd_ready = 1'($urandom);
            endcase
            if (rd_ready) begin
                if (idx == ln - 1) start = 1'b0;
                idx++;
            end
            step();
            cyc++;
        end
        chk("burst_timeout", idx, ln);
        rd_ready = 1'b0; start = 1'b0;
        chk("done_pulse", done, 1);
        chk("end_busy", busy, 0);
        chk("end_valid", rd_valid, 0);
        chk("end_last", rd_last, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; base_addr = '0; len = '0; rd_ready = 1'b0;
        repeat (3) step();
        idle_chk("rst");
        chk("rst_last", rd_last, 0);
        chk("rst_data", rd_data, 0);
        rst = 1'b0;
        step();
        idle_chk("post_rst");

        for (int i = 0; i < 16; i++) wr(i, 8'(8'hA0 + i));

        run_burst(2, 3, 0, 0, 0);
        run_burst(2, 3, 1, 0, 0);
        run_burst(14, 4, 0, 0, 0);
        run_burst(0, 16, 0, 0, 0);

        start = 1'b1; base_addr = 4'd3; len = 5'd0;
        step();
        idle_chk("len0_a");
        start = 1'b0;
        step();
        step();
        idle_chk("len0_b");
        run_burst(2, 3, 2, 1, 0);

        start = 1'b1; base_addr = 4'd0; len = 5'd5;
        step();
        start = 1'b0;
        step();
        rd_ready = 1'b1;
        step();
        chk("abort_word1", rd_data, ref_mem[1]);
        rd_ready = 1'b0; rst = 1'b1;
        step();
        idle_chk("abort");
        chk("abort_last", rd_last, 0);
        chk("abort_data", rd_data, 0);
        rst = 1'b0;
        step();
        idle_chk("abort_after");
        run_burst(0, 5, 0, 0, 0);

        run_burst(5, 2, 0, 0, 1);
        run_burst(5, 1, 0, 0, 0);

        repeat (12) begin
            repeat ($urandom_range(0, 3)) wr($urandom_range(0, 15), 8'($urandom));
            run_burst($urandom_range(0, 15), $urandom_range(1, 16), 2,
                      1'($urandom), ($urandom_range(0, 3) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
